// File: rtl/pll_lock_ctrl_if.sv
// Signals between the PLL lock controller and the PLL / downstream logic.
// The controller uses the slave side; the board side (PLL model, bench) uses master.
interface pll_lock_ctrl_if;
    logic       pll_lock;
    logic       force_relock;
    logic       pll_rst;
    logic       user_rst_n;
    logic       ctrl_locked;
    logic       ctrl_fail;
    logic [1:0] retry_cnt;

    modport master (
        output pll_lock,
        output force_relock,
        input  pll_rst,
        input  user_rst_n,
        input  ctrl_locked,
        input  ctrl_fail,
        input  retry_cnt
    );

    modport slave (
        input  pll_lock,
        input  force_relock,
        output pll_rst,
        output user_rst_n,
        output ctrl_locked,
        output ctrl_fail,
        output retry_cnt
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock with timeout and retry,
// qualifies lock stability and then releases the downstream reset.
module pll_lock_ctrl #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned RELEASE_DLY_CYC  = 16,
    parameter int unsigned MAX_RETRY        = 3
) (
    input  logic           clkin1,
    input  logic           sys_rst_n,
    pll_lock_ctrl_if.slave bus
);

    localparam int unsigned MaxAb  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ?
                                     RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned MaxCd  = (LOCK_STABLE_CYC > RELEASE_DLY_CYC) ?
                                     LOCK_STABLE_CYC : RELEASE_DLY_CYC;
    localparam int unsigned MaxCyc = (MaxAb > MaxCd) ? MaxAb : MaxCd;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    localparam logic [CntW-1:0] RstLast     = CntW'(RST_PULSE_CYC - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that first saw lock is the first of the stable run.
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYC - 2);
    localparam logic [CntW-1:0] ReleaseLast = CntW'(RELEASE_DLY_CYC - 1);
    localparam logic [1:0]      MaxRetry    = 2'(MAX_RETRY);

    localparam logic [2:0] StResetPll = 3'd0;
    localparam logic [2:0] StWaitLock = 3'd1;
    localparam logic [2:0] StStable   = 3'd2;
    localparam logic [2:0] StRelease  = 3'd3;
    localparam logic [2:0] StRun      = 3'd4;
    localparam logic [2:0] StFail     = 3'd5;

    logic            lock_meta_q;
    logic            lock_s_q;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      retry_cnt_q, retry_cnt_d;
    logic            pll_rst_q, pll_rst_d;
    logic            user_rst_n_q, user_rst_n_d;
    logic            ctrl_locked_q, ctrl_locked_d;
    logic            ctrl_fail_q, ctrl_fail_d;

    // pll_lock comes from the PLL's own clock domain.
    always_ff @(posedge clkin1) begin
        if (!sys_rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= bus.pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        case (state_q)
            StResetPll: begin
                if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                end
            end
            StWaitLock: begin
                if (lock_s_q) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    if (retry_cnt_q == MaxRetry) begin
                        state_d = StFail;
                    end else begin
                        state_d     = StResetPll;
                        retry_cnt_d = retry_cnt_q + 2'd1;
                    end
                end
            end
            StStable: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!lock_s_q) begin
                    state_d = StResetPll;
                end else if (cnt_q == ReleaseLast) begin
                    state_d     = StRun;
                    retry_cnt_d = 2'd0;
                end
            end
            StRun: begin
                if (!lock_s_q || bus.force_relock) begin
                    state_d     = StResetPll;
                    retry_cnt_d = 2'd0;
                end
            end
            StFail: begin
                if (bus.force_relock) begin
                    state_d     = StResetPll;
                    retry_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d     = StResetPll;
                retry_cnt_d = 2'd0;
            end
        endcase
    end

    // Shared counter: restarts on every state change, idles in untimed states.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != StRun && state_q != StFail) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        pll_rst_d     = (state_d == StResetPll) || (state_d == StFail);
        user_rst_n_d  = (state_d == StRun);
        ctrl_locked_d = (state_d == StRelease) || (state_d == StRun);
        ctrl_fail_d   = (state_d == StFail);
    end

    always_ff @(posedge clkin1) begin
        if (!sys_rst_n) begin
            state_q       <= StResetPll;
            cnt_q         <= '0;
            retry_cnt_q   <= 2'd0;
            pll_rst_q     <= 1'b1;
            user_rst_n_q  <= 1'b0;
            ctrl_locked_q <= 1'b0;
            ctrl_fail_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            pll_rst_q     <= pll_rst_d;
            user_rst_n_q  <= user_rst_n_d;
            ctrl_locked_q <= ctrl_locked_d;
            ctrl_fail_q   <= ctrl_fail_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.user_rst_n  = user_rst_n_q;
    assign bus.ctrl_locked = ctrl_locked_q;
    assign bus.ctrl_fail   = ctrl_fail_q;
    assign bus.retry_cnt   = retry_cnt_q;

endmodule
